// File: rtl/riscv_pkg.sv
// Shared core constants for the RV32I pipeline.
//   XLEN             architectural register/PC width
//   NOP_INSTR        bubble instruction (addi x0,x0,0)
//   RESET_PC         PC loaded on reset
//   INSTR_ALIGN_BITS low PC bits forced to zero for 4-byte instructions
package riscv_pkg;
   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC         = 32'h0000_0000;
   localparam int          INSTR_ALIGN_BITS = 2;

   // Clear the sub-word bits of a byte target; no misalignment trap is raised.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return {a[XLEN-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus between the fetch stage and a combinational ROM.
//   imem_addr  word address driven by fetch (master)
//   imem_data  instruction returned by the ROM (slave), same cycle
interface fetch_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_data;

   modport master (output imem_addr, input  imem_data);
   modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst   clock, synchronous active-high reset
//   bubble     load a bubble (valid 0, NOP, zero PCs); beats hold
//   hold       keep all fields
//   in_*       fields captured on a normal load
//   valid, instr, pc, pc4  registered outputs
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bubble,
   input  logic                  hold,
   input  logic [DATA_WIDTH-1:0] in_instr,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [XLEN-1:0]       in_pc4,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [XLEN-1:0]       pc,
   output logic [XLEN-1:0]       pc4
);
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         valid <= 1'b0;
         instr <= NOP;
         pc    <= '0;
         pc4   <= '0;
      end else if (!hold) begin
         valid <= 1'b1;
         instr <= in_instr;
         pc    <= in_pc;
         pc4   <= in_pc4;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC register, next-PC mux, fetch counter,
// and the IF/ID register fed from a zero-latency instruction ROM.
//   clk, rst      clock, synchronous active-high reset
//   stall         hold PC, IF/ID and counter (decode load-use hazard)
//   redirect      taken branch/jump from execute; overrides stall
//   redirect_pc   byte target (low 2 bits ignored)
//   imem          ROM bus (master): word address out, instruction in
//   pc            current fetch PC
//   if_id_*       IF/ID register outputs
//   fetch_count   valid instructions captured since reset
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [31:0]           RESET_PC   = riscv_pkg::RESET_PC,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(riscv_pkg::NOP_INSTR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [XLEN-1:0]       redirect_pc,
   fetch_stage_if.master         imem,
   output logic [XLEN-1:0]       pc,
   output logic                  if_id_valid,
   output logic [DATA_WIDTH-1:0] if_id_instr,
   output logic [XLEN-1:0]       if_id_pc,
   output logic [XLEN-1:0]       if_id_pc4,
   output logic [31:0]           fetch_count
);
   logic [XLEN-1:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   // PC bits above the ROM range are dropped: fetch aliases modulo ROM size.
   assign imem.imem_addr = pc[ADDR_WIDTH+1:INSTR_ALIGN_BITS];

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else if (redirect) begin
         pc <= align_pc(redirect_pc);
      end else if (!stall) begin
         pc          <= pc_plus4;
         fetch_count <= fetch_count + 32'd1;
      end
   end

   // The instruction on imem_data during a redirect is wrong-path: bubble it.
   if_id_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .NOP        (NOP_INSTR)
   ) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .bubble   (redirect),
      .hold     (stall),
      .in_instr (imem.imem_data),
      .in_pc    (pc),
      .in_pc4   (pc_plus4),
      .valid    (if_id_valid),
      .instr    (if_id_instr),
      .pc       (if_id_pc),
      .pc4      (if_id_pc4)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small combinational ROM model.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst, stall, redirect;
   logic [31:0] redirect_pc, pc, if_id_pc, if_id_pc4, fetch_count, if_id_instr;
   logic        if_id_valid;
   logic [31:0] rom [256];
   int          total = 0, passed = 0;

   fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) imem ();

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (imem.master),
      .pc          (pc),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_pc4   (if_id_pc4),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;
   assign imem.imem_data = rom[imem.imem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic [31:0] p4);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
      chk({tag, ".instr"}, if_id_instr, i);
      chk({tag, ".pc"},    if_id_pc,    p);
      chk({tag, ".pc4"},   if_id_pc4,   p4);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'h0;
      rom[0]  = 32'h00052503;
      rom[1]  = 32'h0045a583;
      rom[2]  = 32'h00b50633;
      rom[3]  = 32'h00c2a223;
      rom[4]  = 32'h00000033;
      rom[12] = 32'h00c6f6b3;
      rom[13] = 32'h00d70733;

      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      step(); step();
      chk_ifid("reset", 1'b0, 32'h13, 32'h0, 32'h0);
      chk("reset.pc", pc, 32'h0);
      chk("reset.count", fetch_count, 32'd0);
      chk("reset.addr", {24'd0, imem.imem_addr}, 32'd0);

      rst = 1'b0;
      step(); chk_ifid("run0", 1'b1, 32'h00052503, 32'h0, 32'h4);
      chk("run0.pc", pc, 32'h4);
      step(); chk_ifid("run1", 1'b1, 32'h0045a583, 32'h4, 32'h8);
      step(); chk_ifid("run2", 1'b1, 32'h00b50633, 32'h8, 32'hC);
      chk("run2.count", fetch_count, 32'd3);
      chk("run2.addr", {24'd0, imem.imem_addr}, 32'd3);

      stall = 1'b1;
      for (int n = 0; n < 2; n++) begin
         step();
         chk_ifid("stall", 1'b1, 32'h00b50633, 32'h8, 32'hC);
         chk("stall.addr", {24'd0, imem.imem_addr}, 32'd3);
         chk("stall.count", fetch_count, 32'd3);
         chk("stall.pc", pc, 32'hC);
      end
      stall = 1'b0;
      step(); chk_ifid("resume", 1'b1, 32'h00c2a223, 32'hC, 32'h10);
      chk("resume.count", fetch_count, 32'd4);

      redirect = 1'b1; redirect_pc = 32'h30;
      step(); chk_ifid("redir.bubble", 1'b0, 32'h13, 32'h0, 32'h0);
      chk("redir.count", fetch_count, 32'd4);
      chk("redir.pc", pc, 32'h30);
      redirect = 1'b0;
      step(); chk_ifid("redir.tgt", 1'b1, 32'h00c6f6b3, 32'h30, 32'h34);
      chk("redir.tgt.count", fetch_count, 32'd5);

      redirect = 1'b1; redirect_pc = 32'h33; stall = 1'b1;
      step(); chk_ifid("rs.bubble", 1'b0, 32'h13, 32'h0, 32'h0);
      chk("rs.pc", pc, 32'h30);
      redirect = 1'b0; stall = 1'b0;
      step(); chk_ifid("rs.tgt", 1'b1, 32'h00c6f6b3, 32'h30, 32'h34);
      chk("rs.count", fetch_count, 32'd6);

      redirect = 1'b1; redirect_pc = 32'h3FC;
      step(); chk("wrap.addr0", {24'd0, imem.imem_addr}, 32'd255);
      redirect = 1'b0;
      step(); chk_ifid("wrap.top", 1'b1, 32'h0, 32'h3FC, 32'h400);
      chk("wrap.pc", pc, 32'h400);
      chk("wrap.addr", {24'd0, imem.imem_addr}, 32'd0);
      step(); chk_ifid("wrap.alias", 1'b1, 32'h00052503, 32'h400, 32'h404);
      chk("wrap.count", fetch_count, 32'd8);

      redirect = 1'b1; redirect_pc = 32'h1C;
      step(); chk("pre_rst.pc", pc, 32'h1C);
      rst = 1'b1; stall = 1'b1; redirect_pc = 32'h80;
      step(); chk_ifid("midrst", 1'b0, 32'h13, 32'h0, 32'h0);
      chk("midrst.pc", pc, 32'h0);
      chk("midrst.count", fetch_count, 32'd0);
      chk("midrst.addr", {24'd0, imem.imem_addr}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined RV32I core. Holds the program counter, drives the word address of the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It also handles decode-stage stalls, execute-stage branch/jump redirects and a fetched-instruction counter. It sits between the PC-redirect logic (execute) and the decode stage.

## Interface

- DATA_WIDTH, 32, instruction width; must equal ROM data width
- ADDR_WIDTH, 8, ROM word-address width (ROM depth 2**ADDR_WIDTH words)
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and IF/ID register (load-use hazard from decode)
- redirect  in  1  taken branch/jump resolved in execute
- redirect_pc  in  32  byte target of redirect
- imem_addr  out  ADDR_WIDTH  ROM word address = pc[ADDR_WIDTH+1:2]
- imem_data  in  DATA_WIDTH  ROM instruction, combinational from imem_addr
- pc  out  32  current fetch PC
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  DATA_WIDTH  captured instruction
- if_id_pc  out  32  PC of captured instruction
- if_id_pc4  out  32  if_id_pc + 4
- fetch_count  out  32  number of valid instructions captured since reset

## Operation

- Per-edge priority: rst > redirect > stall > normal.
- rst: pc<=RESET_PC; if_id_valid<=0; if_id_instr<=NOP_INSTR; if_id_pc<=0; if_id_pc4<=0; fetch_count<=0.
- redirect (ignores stall): pc<={redirect_pc[31:2],2'b00}; IF/ID <= bubble (valid 0, instr NOP_INSTR, pc fields 0). The instruction on imem_data this cycle is wrong-path and is discarded. redirect_pc[1:0] are ignored; no misalignment trap.
- stall (no redirect): pc, all IF/ID fields and fetch_count hold.
- normal: pc<=pc+4 (32-bit, wraps at 2**32); IF/ID <= {1, imem_data, pc, pc+4}; fetch_count<=fetch_count+1 (wraps at 2**32).
- imem_addr is combinational from the pc register. PC bits above ADDR_WIDTH+1 are ignored, so fetch aliases modulo 2**(ADDR_WIDTH+2) bytes. Unpopulated ROM words return 0 and are captured as valid; illegal-instruction detection belongs to decode.
- if_id_pc4 is computed from the pc register, not from if_id_pc.

## Timing

- ROM is zero-latency: the instruction for pc is available in the same cycle and lands in IF/ID at the next edge. Fetch-to-decode latency is 1 cycle.
- First edge after rst deasserts: IF/ID = word at RESET_PC, pc = RESET_PC+4.
- Redirect penalty is 1 bubble. The edge that samples redirect loads the target. At the next edge, IF/ID holds the target instruction.
- stall held N cycles freezes all outputs for N cycles. Fetch resumes at the held pc with no duplicate or lost instruction.
- rst asserted mid-operation (including with stall or redirect high) gives reset values on all registered outputs at that edge. imem_addr = RESET_PC[ADDR_WIDTH+1:2] immediately after.

## Structure

- Shared package riscv_pkg: XLEN=32, NOP_INSTR, RESET_PC, instruction-alignment constant (2 LSBs).
- One sub-module, if_id_reg: holds the valid, instr, pc and pc4 fields, with hold (stall), bubble (redirect) and load controls. fetch_stage contains the PC register, next-PC mux and fetch_count.

## Test plan

- Reset, then 3 free-running cycles. IF/ID instr/pc sequence is 0x00052503/0x0, 0x0045a583/0x4, 0x00b50633/0x8. fetch_count=3, if_id_pc4=0xC.
- stall high for 2 cycles with pc=0xC. imem_addr stays 3, all IF/ID fields and fetch_count frozen. After release, IF/ID = 0x00c2a223/0xC.
- redirect to 0x30. Next edge: if_id_valid=0, instr=0x00000013, fetch_count unchanged. Following edge: instr=0x00c6f6b3, pc=0x30, pc4=0x34.
- redirect to 0x33 together with stall. Redirect wins: pc=0x30, bubble inserted, then instr=0x00c6f6b3.
- Redirect to 0x3FC. Captures 0x00000000 as valid at pc 0x3FC. Next pc=0x400, imem_addr=0, next IF/ID instr=0x00052503 with pc 0x400.
- rst pulsed at pc=0x1C with stall and redirect high. All outputs at reset values after that edge, imem_addr=0.
